uart_param_core: RTL and testbench

Parametrised UART transceiver core, successor to the fixed 8N1 UART. Adds configurable data width, parity, stop bits, an oversampled majority-vote receiver, parity/framing error and break detection, and a configurable idle-gap ("sentence received") detector. TX and RX use valid/ready and strobe interfaces so the existing fifo block attaches externally.

---
 rtl/uart_param_core_if.sv | 28 ++
 rtl/uart_param_core.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_param_core_if.sv
// Host-side bundle of the UART core: TX valid/ready handshake and RX strobes/flags.
// The core uses the slave modport, the attached logic (fifo, bench) the master modport.
interface uart_param_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_error;
    logic                 rx_framing_error;
    logic                 rx_break;
    logic                 rx_idle;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_error,
               rx_framing_error, rx_break, rx_idle
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_error,
               rx_framing_error, rx_break, rx_idle
    );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised UART: configurable width/parity/stop, oversampled majority-vote receiver
// with parity/framing/break detection and an idle-gap strobe.
module uart_param_core #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int OVERSAMPLE      = 8,
    parameter int IDLE_GAP_FRAMES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_param_core_if.slave      bus,
    output logic                  uart_tx_pin,
    input  logic                  uart_rx_pin
);
    localparam int TICK_DIV   = (CLOCK_FREQUENCY + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int BIT_CLKS   = TICK_DIV * OVERSAMPLE;
    localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int STOP_CLKS  = STOP_BITS * BIT_CLKS;
    localparam int IDLE_CLKS  = IDLE_GAP_FRAMES * FRAME_BITS * BIT_CLKS;

    localparam int TXC_W  = $clog2(STOP_CLKS + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS + 1);
    localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

    localparam logic [TXC_W-1:0]  TX_BIT_LAST  = TXC_W'(BIT_CLKS - 1);
    localparam logic [TXC_W-1:0]  TX_STOP_LAST = TXC_W'(STOP_CLKS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_A       = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_B       = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_C       = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] SAMP_END     = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST    = BIDX_W'(DATA_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(IDLE_CLKS - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BIDX_W-1:0]    tx_bidx_q, tx_bidx_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_ready, tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == TX_BIT_LAST);
    // Ready also in the final stop clock so back-to-back frames have no gap.
    assign tx_ready   = (tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_cnt_q == TX_STOP_LAST));

    // NOTE: every variable gets a default before the case, so no path infers a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + TXC_W'(1);
        tx_shift_d = tx_shift_q;
        tx_bidx_d  = tx_bidx_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: tx_cnt_d = '0;
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bidx_d  = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bidx_d  = tx_bidx_q + BIDX_W'(1);
                    if (tx_bidx_q == BIDX_LAST)
                        tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == TX_STOP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
        if (tx_ready && bus.tx_valid) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = bus.tx_data;
            tx_par_d   = (^bus.tx_data) ^ (PARITY == 1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bidx_q  <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bidx_q  <= tx_bidx_d;
            tx_par_q   <= tx_par_d;
        end
    end

    always_comb begin
        case (tx_state_q)
            TX_START:  uart_tx_pin = 1'b0;
            TX_DATA:   uart_tx_pin = tx_shift_q[0];
            TX_PARITY: uart_tx_pin = tx_par_q;
            default:   uart_tx_pin = 1'b1;
        endcase
    end

    assign bus.tx_ready = tx_ready;
    assign bus.tx_busy  = (tx_state_q != TX_IDLE);

    // ---------------- receiver ----------------
    logic [1:0]           rx_sync_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
    logic [SAMP_W-1:0]    rx_samp_q, rx_samp_d;
    logic [1:0]           rx_vote_q, rx_vote_d;
    logic [BIDX_W-1:0]    rx_bidx_q, rx_bidx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic                 rx_valid_q, rx_valid_d, rx_break_q, rx_break_d;
    logic                 rx_idle_q, rx_idle_d, idle_arm_q, idle_arm_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic       rxd, rx_active, rx_tick, rx_decide, rx_bit_end, rx_maj, rx_ones;
    logic [1:0] rx_votes;

    assign rxd        = rx_sync_q[1];
    assign rx_active  = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);
    assign rx_tick    = (rx_tick_q == TICK_LAST);
    assign rx_decide  = rx_tick && (rx_samp_q == SAMP_C);
    assign rx_bit_end = rx_tick && (rx_samp_q == SAMP_END);
    assign rx_votes   = rx_vote_q + {1'b0, rxd};
    assign rx_maj     = rx_votes[1];
    assign rx_ones    = (^rx_shift_q) ^ rx_par_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_samp_d  = rx_samp_q;
        rx_vote_d  = rx_vote_q;
        rx_bidx_d  = rx_bidx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        rx_break_d = 1'b0;
        rx_idle_d  = 1'b0;
        idle_cnt_d = idle_cnt_q;
        idle_arm_d = idle_arm_q;

        if (rx_active) begin
            rx_tick_d = rx_tick ? '0 : rx_tick_q + TICK_W'(1);
            if (rx_tick) begin
                rx_samp_d = rx_bit_end ? '0 : rx_samp_q + SAMP_W'(1);
                if ((rx_samp_q == SAMP_A) || (rx_samp_q == SAMP_B))
                    rx_vote_d = rx_votes;
                if (rx_bit_end)
                    rx_vote_d = '0;
            end
        end

        if ((rx_state_q == RX_IDLE) && idle_arm_q) begin
            if (idle_cnt_q == IDLE_LAST) begin
                rx_idle_d  = 1'b1;
                idle_arm_d = 1'b0;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = '0;
                    rx_samp_d  = '0;
                    rx_vote_d  = '0;
                    idle_cnt_d = '0;
                    idle_arm_d = 1'b0;
                end
            end
            RX_START: begin
                if (rx_decide && rx_maj) begin
                    rx_state_d = RX_IDLE;
                end else if (rx_bit_end) begin
                    rx_bidx_d  = '0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_decide)
                    rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_end) begin
                    rx_bidx_d = rx_bidx_q + BIDX_W'(1);
                    if (rx_bidx_q == BIDX_LAST)
                        rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_decide)
                    rx_par_d = rx_maj;
                if (rx_bit_end)
                    rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                // The frame ends at the first stop-bit decision so a new start can be caught mid-stop.
                if (rx_decide) begin
                    idle_cnt_d = '0;
                    idle_arm_d = 1'b1;
                    if (!rx_maj && (rx_shift_q == '0) && ((PARITY == 0) || !rx_par_q)) begin
                        rx_break_d = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = (PARITY == 1) ? !rx_ones : (PARITY == 2) ? rx_ones : 1'b0;
                        rx_ferr_d  = !rx_maj;
                        rx_state_d = rx_maj ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd)
                    rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_samp_q  <= '0;
            rx_vote_q  <= '0;
            rx_bidx_q  <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_break_q <= 1'b0;
            rx_idle_q  <= 1'b0;
            idle_cnt_q <= '0;
            idle_arm_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx_pin};
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_samp_q  <= rx_samp_d;
            rx_vote_q  <= rx_vote_d;
            rx_bidx_q  <= rx_bidx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
            rx_break_q <= rx_break_d;
            rx_idle_q  <= rx_idle_d;
            idle_cnt_q <= idle_cnt_d;
            idle_arm_q <= idle_arm_d;
        end
    end

    assign bus.rx_data          = rx_data_q;
    assign bus.rx_valid         = rx_valid_q;
    assign bus.rx_parity_error  = rx_perr_q;
    assign bus.rx_framing_error = rx_ferr_q;
    assign bus.rx_break         = rx_break_q;
    assign bus.rx_idle          = rx_idle_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three instances (8N1 default, 7E2 looped back, 8O1) driven by
// directed steps and random bytes, checked against a frame-level model built from arithmetic.
module tb_uart_param_core;
    localparam int BIT     = 232;
    localparam int FRAME_A = 10 * BIT;
    localparam int FRAME_B = 11 * BIT;
    typedef logic [10:0] rec_t;   // {parity_error, framing_error, 9-bit data}

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_a, tx_b, tx_c;
    logic rx_a = 1'b1;
    logic rx_c = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    rec_t q_a[$], q_b[$], q_c[$];
    int   brk_a = 0, brk_b = 0, brk_c = 0, idle_a = 0, last_v_a = 0, idle_cyc_a = 0;

    uart_param_core_if #(.DATA_BITS(8)) if_a ();
    uart_param_core_if #(.DATA_BITS(7)) if_b ();
    uart_param_core_if #(.DATA_BITS(8)) if_c ();

    uart_param_core u_a (
        .clock(clk), .reset(rst), .bus(if_a.slave), .uart_tx_pin(tx_a), .uart_rx_pin(rx_a)
    );
    uart_param_core #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clock(clk), .reset(rst), .bus(if_b.slave), .uart_tx_pin(tx_b), .uart_rx_pin(tx_b)
    );
    uart_param_core #(.PARITY(1)) u_c (
        .clock(clk), .reset(rst), .bus(if_c.slave), .uart_tx_pin(tx_c), .uart_rx_pin(rx_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (if_a.rx_valid === 1'b1) begin
            q_a.push_back({if_a.rx_parity_error, if_a.rx_framing_error, 1'b0, if_a.rx_data});
            last_v_a <= cyc;
        end
        if (if_a.rx_break === 1'b1) brk_a <= brk_a + 1;
        if (if_a.rx_idle === 1'b1) begin
            idle_a     <= idle_a + 1;
            idle_cyc_a <= cyc;
        end
        if (if_b.rx_valid === 1'b1)
            q_b.push_back({if_b.rx_parity_error, if_b.rx_framing_error, 2'b00, if_b.rx_data});
        if (if_b.rx_break === 1'b1) brk_b <= brk_b + 1;
        if (if_c.rx_valid === 1'b1)
            q_c.push_back({if_c.rx_parity_error, if_c.rx_framing_error, 1'b0, if_c.rx_data});
        if (if_c.rx_break === 1'b1) brk_c <= brk_c + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t at(input rec_t q[$], input int i);
        return (i < q.size()) ? q[i] : 11'h7ff;
    endfunction

    // Line bits of one 8-bit frame, LSB = start bit; pmode 1 = odd, 2 = even.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit with_par,
                                               input int pmode, input bit bad_par, input bit stop_v);
        int   ones;
        logic p;
        ones = $countones(d);
        p = (pmode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if (bad_par) p = ~p;
        if (with_par) return {5'b11111, stop_v, p, d, 1'b0};
        return {6'b111111, stop_v, d, 1'b0};
    endfunction

    task automatic drive_rx(input bit on_c, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (on_c) rx_c = bits[i];
            else      rx_a = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic tx_a_frame(input logic [7:0] d, input string tag);
        logic [15:0] exp_bits;
        int pin_err[10];
        int ready_low, busy_err, k;
        logic ready_last;
        exp_bits = frame_bits(d, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) pin_err[i] = 0;
        ready_low = 0;
        busy_err = 0;
        ready_last = 1'b0;
        @(negedge clk);
        check({tag, "_ready_idle"}, if_a.tx_ready, 1);
        if_a.tx_data = d;
        if_a.tx_valid = 1'b1;
        for (int j = 1; j <= FRAME_A; j++) begin
            @(negedge clk);
            if (j == 1) if_a.tx_valid = 1'b0;
            if_a.tx_data = 8'($urandom);
            k = (j - 1) / BIT;
            if (tx_a !== exp_bits[k]) pin_err[k]++;
            if (if_a.tx_ready === 1'b0) ready_low++;
            if (if_a.tx_busy !== 1'b1) busy_err++;
            ready_last = if_a.tx_ready;
        end
        for (int i = 0; i < 10; i++) check($sformatf("%s_bit%0d_errs", tag, i), pin_err[i], 0);
        check({tag, "_ready_low_clks"}, ready_low, FRAME_A - 1);
        check({tag, "_ready_last_stop"}, ready_last, 1);
        check({tag, "_busy_errs"}, busy_err, 0);
        @(negedge clk);
        check({tag, "_pin_after"}, tx_a, 1);
        check({tag, "_busy_after"}, if_a.tx_busy, 0);
    endtask

    task automatic b_send(input logic [6:0] d, output int hs);
        int n;
        if_b.tx_data = d;
        if_b.tx_valid = 1'b1;
        n = 0;
        while (if_b.tx_ready !== 1'b1 && n < 4 * FRAME_B) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        hs = cyc;
    endtask

    initial begin
        logic [6:0] b_data[5];
        int         hs[5];
        int         base, b0, i0, n;
        logic [7:0] r;
        logic [7:0] a_data[3];

        if_a.tx_valid = 1'b0; if_a.tx_data = '0;
        if_b.tx_valid = 1'b0; if_b.tx_data = '0;
        if_c.tx_valid = 1'b0; if_c.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_pin", tx_a, 1);
        check("rst_tx_ready", if_a.tx_ready, 1);
        check("rst_tx_busy", if_a.tx_busy, 0);
        check("rst_rx_data", if_a.rx_data, 0);
        check("rst_strobes", {if_a.rx_valid, if_a.rx_break, if_a.rx_idle,
                              if_a.rx_parity_error, if_a.rx_framing_error}, 0);
        check("rst_tx_pin_b", tx_b, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: default TX framing and ready/busy timing
        tx_a_frame(8'h55, "tx55");
        tx_a_frame(8'($urandom), "txrnd");

        // 2: 7E2 loopback, back-to-back frames
        b_data[0] = 7'h23; b_data[1] = 7'h7f; b_data[2] = 7'h00;
        b_data[3] = 7'($urandom); b_data[4] = 7'($urandom);
        base = q_b.size();
        for (int i = 0; i < 5; i++) b_send(b_data[i], hs[i]);
        if_b.tx_valid = 1'b0;
        n = 0;
        while (q_b.size() < base + 5 && n < 2 * FRAME_B) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * BIT) @(negedge clk);
        check("b_gap01", hs[1] - hs[0], FRAME_B);
        check("b_gap12", hs[2] - hs[1], FRAME_B);
        check("b_rx_count", q_b.size() - base, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("b_rx%0d", i), at(q_b, base + i), 11'(b_data[i]));
        check("b_no_break", brk_b, 0);

        // 3: odd parity error, then framing error and WAIT_HIGH hold
        base = q_c.size();
        drive_rx(1'b1, frame_bits(8'ha3, 1'b1, 1, 1'b1, 1'b1), 11);
        drive_rx(1'b1, frame_bits(8'ha3, 1'b1, 1, 1'b0, 1'b0), 11);
        repeat (3 * BIT) @(negedge clk);
        check("c_count_low", q_c.size() - base, 2);
        check("c_parity_err", at(q_c, base), 11'h4a3);
        check("c_framing_err", at(q_c, base + 1), 11'h2a3);
        check("c_no_break", brk_c, 0);
        rx_c = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        r = 8'($urandom);
        drive_rx(1'b1, frame_bits(r, 1'b1, 1, 1'b0, 1'b1), 11);
        check("c_count_after", q_c.size() - base, 3);
        check("c_good_frame", at(q_c, base + 2), 11'(r));

        // 4: short low glitch is a false start, then a good frame
        base = q_a.size();
        b0 = brk_a;
        rx_a = 1'b0;
        repeat (100) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_no_valid", q_a.size() - base, 0);
        check("glitch_no_break", brk_a - b0, 0);
        drive_rx(1'b0, frame_bits(8'h3c, 1'b0, 0, 1'b0, 1'b1), 10);
        check("a_3c_count", q_a.size() - base, 1);
        check("a_3c_rec", at(q_a, base), 11'h03c);
        check("a_3c_rx_data", if_a.rx_data, 8'h3c);

        // 5: break, no retrigger while held low
        base = q_a.size();
        b0 = brk_a;
        rx_a = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("brk_once", brk_a - b0, 1);
        repeat (4 * BIT) @(negedge clk);
        check("brk_held_low", brk_a - b0, 1);
        rx_a = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("brk_after_high", brk_a - b0, 1);
        check("brk_no_valid", q_a.size() - base, 0);
        check("brk_rx_data_kept", if_a.rx_data, 8'h3c);

        // 6: three back-to-back frames, then idle gap
        base = q_a.size();
        i0 = idle_a;
        for (int i = 0; i < 3; i++) begin
            a_data[i] = 8'($urandom);
            drive_rx(1'b0, frame_bits(a_data[i], 1'b0, 0, 1'b0, 1'b1), 10);
        end
        repeat (FRAME_A + 400) @(negedge clk);
        check("idle_rx_count", q_a.size() - base, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("idle_rx%0d", i), at(q_a, base + i), 11'(a_data[i]));
        check("idle_pulses", idle_a - i0, 1);
        check("idle_delay", idle_cyc_a - last_v_a, FRAME_A);

        // Reset in the middle of a TX frame and an RX frame
        base = q_a.size();
        b0 = brk_a;
        @(negedge clk);
        if_a.tx_data = 8'($urandom);
        if_a.tx_valid = 1'b1;
        @(negedge clk);
        if_a.tx_valid = 1'b0;
        rx_a = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("mid_busy", if_a.tx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pin", tx_a, 1);
        check("mid_rst_ready", if_a.tx_ready, 1);
        check("mid_rst_busy", if_a.tx_busy, 0);
        @(negedge clk);
        rx_a = 1'b1;
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("mid_pin_idle", tx_a, 1);
        check("mid_no_valid", q_a.size() - base, 0);
        check("mid_no_break", brk_a - b0, 0);
        check("mid_rx_data_rst", if_a.rx_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
